// File: rtl/robertson_ctrl.sv
// Sequencing FSM for the Robertson signed shift-add multiplier datapath.
// Loads operands, runs WIDTH add/shift iterations, subtracts on the last step.
module robertson_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       q0,
   output logic       ld,
   output logic [1:0] add_sel,
   output logic       acc_en,
   output logic       shift,
   output logic       busy,
   output logic       done
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_ADD   = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [1:0] SEL_ZERO = 2'd0;
   localparam logic [1:0] SEL_POS  = 2'd1;
   localparam logic [1:0] SEL_NEG  = 2'd2;

   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lastIter;

   assign lastIter = (cnt_q == LAST_ITER);

   // Next-state and iteration counter; unused encodings fall back to IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d   = '0;
            state_d = S_ADD;
         end
         S_ADD: begin
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (lastIter) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = S_ADD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Moore decodes plus the q0-dependent adder controls, live only in ADD.
   always_comb begin
      ld      = 1'b0;
      add_sel = SEL_ZERO;
      acc_en  = 1'b0;
      shift   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_LOAD: begin
            ld   = 1'b1;
            busy = 1'b1;
         end
         S_ADD: begin
            busy   = 1'b1;
            acc_en = q0;
            if (q0) begin
               add_sel = lastIter ? SEL_NEG : SEL_POS;
            end
         end
         S_SHIFT: begin
            shift = 1'b1;
            busy  = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
            busy = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_robertson_ctrl.sv
// Directed bench for robertson_ctrl: one WIDTH=4 and one WIDTH=8 instance
// share clock and reset; expected outputs come from a cycle-indexed model.
module tb_robertson_ctrl;

   logic clk;
   logic reset;

   logic       start4, q04;
   logic       ld4, acc4, sh4, busy4, done4;
   logic [1:0] sel4;

   logic       start8, q08;
   logic       ld8, acc8, sh8, busy8, done8;
   logic [1:0] sel8;

   int nCompared;
   int nMismatched;

   robertson_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .q0(q04),
      .ld(ld4), .add_sel(sel4), .acc_en(acc4), .shift(sh4),
      .busy(busy4), .done(done4)
   );

   robertson_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .q0(q08),
      .ld(ld8), .add_sel(sel8), .acc_en(acc8), .shift(sh8),
      .busy(busy8), .done(done8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed as {ld, add_sel[1:0], acc_en, shift, busy, done}.
   function automatic logic [6:0] out4();
      return {ld4, sel4, acc4, sh4, busy4, done4};
   endfunction

   function automatic logic [6:0] out8();
      return {ld8, sel8, acc8, sh8, busy8, done8};
   endfunction

   // Expected outputs for cycle c of an operation whose start was sampled at cycle 0.
   function automatic logic [6:0] expOut(int w, logic [31:0] mult, int c);
      logic       eLd, eAcc, eSh, eBusy, eDone;
      logic [1:0] eSel;
      int         it;
      eLd = 1'b0; eAcc = 1'b0; eSh = 1'b0; eBusy = 1'b0; eDone = 1'b0;
      eSel = 2'd0;
      if (c == 1) eLd = 1'b1;
      if (c >= 2 && c <= 2 * w + 1) begin
         it = (c - 2) / 2;
         if (c % 2 == 0) begin
            if (mult[it]) begin
               eAcc = 1'b1;
               eSel = (it == w - 1) ? 2'd2 : 2'd1;
            end
         end else begin
            eSh = 1'b1;
         end
      end
      if (c == 2 * w + 2) eDone = 1'b1;
      eBusy = (c >= 1 && c <= 2 * w + 2);
      return {eLd, eSel, eAcc, eSh, eBusy, eDone};
   endfunction

   // q0 the datapath would present in cycle c; outside ADD it is held high
   // so that any leak of q0 into acc_en/add_sel shows up.
   function automatic logic q0For(int w, logic [31:0] mult, int c);
      if (c >= 2 && c <= 2 * w + 1 && (c % 2 == 0)) return mult[(c - 2) / 2];
      return 1'b1;
   endfunction

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] got;
      reset = 1'b1; start4 = 1'b0; start8 = 1'b0; q04 = 1'b1; q08 = 1'b1;
      #2;
      got = out4();
      nCompared++;
      if (got !== 7'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_w4 got=%b want=%b", got, 7'd0);
      end
      got = out8();
      nCompared++;
      if (got !== 7'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_w8 got=%b want=%b", got, 7'd0);
      end
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         got = out4();
         nCompared++;
         if (got !== 7'd0) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_idle c=%0d got=%b want=%b", c, got, 7'd0);
         end
         nextCycle();
      end
   endtask

   // Single operation on the WIDTH=4 instance, checked cycle by cycle.
   task automatic test_op4(input logic [31:0] mult, input string name);
      logic [6:0] got, want;
      for (int c = 0; c <= 11; c++) begin
         start4 = (c == 0);
         q04    = q0For(4, mult, c);
         @(negedge clk);
         got  = out4();
         want = expOut(4, mult, c);
         nCompared++;
         if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL %s c=%0d got=%b want=%b", name, c, got, want);
         end
         nextCycle();
      end
      start4 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [6:0] got, want;
      logic [31:0] mult;
      mult = 32'h5;
      for (int c = 0; c <= 22; c++) begin
         start4 = 1'b1;
         q04    = q0For(4, mult, c % 11);
         @(negedge clk);
         got  = out4();
         want = expOut(4, mult, c % 11);
         nCompared++;
         if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL back_to_back c=%0d got=%b want=%b", c, got, want);
         end
         nextCycle();
      end
      start4 = 1'b0;
      // Cycle 23 of the held-start stream is the third LOAD; let it drain.
      for (int c = 0; c < 12; c++) nextCycle();
   endtask

   task automatic test_reset_midop();
      logic [6:0] got, want;
      logic [31:0] mult;
      mult = 32'h5;
      for (int c = 0; c <= 5; c++) begin
         start4 = (c == 0);
         q04    = q0For(4, mult, c);
         @(negedge clk);
         got  = out4();
         want = expOut(4, mult, c);
         nCompared++;
         if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL midop_pre c=%0d got=%b want=%b", c, got, want);
         end
         if (c < 5) nextCycle();
      end
      start4 = 1'b0;
      #1 reset = 1'b1;
      #1;
      got = out4();
      nCompared++;
      if (got !== 7'd0) begin
         nMismatched++;
         $display("[TB] FAIL midop_async_clear got=%b want=%b", got, 7'd0);
      end
      #1 reset = 1'b0;
      nextCycle();
      for (int c = 0; c < 14; c++) begin
         q04 = 1'b1;
         @(negedge clk);
         got = out4();
         nCompared++;
         if (got !== 7'd0) begin
            nMismatched++;
            $display("[TB] FAIL midop_abandoned c=%0d got=%b want=%b", c, got, 7'd0);
         end
         nextCycle();
      end
      test_op4(32'h5, "after_reset_op");
   endtask

   task automatic test_w8_all_ones();
      logic [6:0] got, want;
      logic [31:0] mult;
      mult = 32'hFF;
      for (int c = 0; c <= 19; c++) begin
         start8 = (c == 0);
         q08    = q0For(8, mult, c);
         @(negedge clk);
         got  = out8();
         want = expOut(8, mult, c);
         nCompared++;
         if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL w8_ones c=%0d got=%b want=%b", c, got, want);
         end
         nextCycle();
      end
      start8 = 1'b0;
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      test_reset();
      test_op4(32'h5, "w4_0101");
      test_op4(32'h9, "w4_1001");
      test_back_to_back();
      test_reset_midop();
      test_w8_all_ones();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/robertson_ctrl.md
# robertson_ctrl

Sequencing FSM for the Robertson signed (two's-complement) shift-add multiplier datapath. It accepts a start request and loads the operand registers. It then runs WIDTH add/shift iterations, driving the 3:1 adder-operand mux select, accumulator write enable and shift enable from the live multiplier LSB. The final iteration selects the negated multiplicand to apply the sign correction. It sits between the lab top level (start/done) and the accumulator/multiplier-register datapath.

## Interface
- WIDTH, 8, operand width in bits and number of iterations; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- q0  input  1  current LSB of the datapath multiplier (Q) register.
- ld  output  1  load multiplicand/multiplier registers and clear accumulator.
- add_sel  output  2  operand-mux select: 0 = zero, 1 = +multiplicand, 2 = −multiplicand; 3 is never driven.
- acc_en  output  1  write adder result into accumulator.
- shift  output  1  arithmetic right shift of {acc, Q}.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse; product valid in datapath.

## Operation
- States: IDLE, LOAD, ADD, SHIFT, DONE. State register and iteration counter cnt ($clog2(WIDTH) bits) are the only flops.
- IDLE: all outputs 0. Goes to LOAD when start=1, else stays in IDLE.
- LOAD: ld=1; cnt cleared to 0; goes to ADD.
- ADD: acc_en=q0. If q0=1, add_sel=2 when cnt==WIDTH−1, else add_sel=1. If q0=0, add_sel=0. Goes to SHIFT.
- SHIFT: shift=1. If cnt==WIDTH−1, goes to DONE. Otherwise cnt increments by 1 and the FSM goes to ADD.
- DONE: done=1; goes to IDLE unconditionally.
- ld, shift, busy and done are Moore decodes of state. add_sel and acc_en are Mealy in ADD only (they depend on q0) and are 0 in every other state.
- start is ignored outside IDLE, including in the DONE cycle. A start held high continuously begins a new operation on the first IDLE cycle.
- cnt never wraps inside an operation. It is don't-care outside LOAD..SHIFT but must not alter any output.
- Illegal state encodings recover to IDLE on the next clock.

## Timing
- Reset (asynchronous) forces state=IDLE and cnt=0 immediately, without waiting for a clock edge. All outputs (ld, add_sel, acc_en, shift, busy, done) are 0 while reset is high and in the first cycle after release.
- Reset mid-operation abandons the operation: no done pulse, and no further ld/acc_en/shift.
- Call the cycle in which start is sampled high in IDLE cycle 0.
  - Cycle 1: LOAD (ld=1, busy=1).
  - Cycles 2..2·WIDTH+1: ADD/SHIFT alternate, with ADD on even cycles.
  - Cycle 2·WIDTH+2: DONE (done=1).
  - Cycle 2·WIDTH+3: IDLE.
- Minimum start-to-start spacing is 2·WIDTH+3 cycles.
- q0 must be stable before the clock edge that ends each ADD cycle. The datapath updates Q only on shift, so q0 is constant throughout each ADD cycle.
- Exactly one of ld, acc_en, shift is high in any cycle, or none.

## Test plan
- Reset: assert reset asynchronously between clock edges → all outputs go to 0 without a clock edge; after release, busy=0 and done=0 until start.
- WIDTH=4, multiplier 0101 (q0 sequence across ADD cycles 1,0,1,0): start at cycle 0 → ld at cycle 1; add_sel/acc_en = 1/1, 0/0, 1/1, 0/0 at cycles 2,4,6,8; shift at 3,5,7,9; done at cycle 10 only; busy high for cycles 1–10.
- WIDTH=4, multiplier 1001 (q0 sequence 1,0,0,1) → add_sel=1 at cycle 2, 0 at 4 and 6, and 2 at cycle 8 (last-step subtract); acc_en high only at 2 and 8.
- WIDTH=4, start held high continuously → done at cycles 10 and 21; start ignored in cycles 1–10; the second ld is at cycle 12.
- WIDTH=4, reset pulsed during cycle 5 → no done pulse; after release, a start at cycle N gives done at N+10.
- WIDTH=8, multiplier 0xFF (q0 always 1) → add_sel=1 for the first 7 ADD cycles and 2 on the 8th (cycle 16); done at cycle 18.
